// File: rtl/seg_scan_display_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// seg_scan_display_pkg : shared constants and types (rev 1.0)
// ------------------------------------------------------------------
package seg_scan_display_pkg;

  // Segment order {g,f,e,d,c,b,a}, active low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int DISP_MAX = 9999;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_display_bin2bcd.sv
`default_nettype none
// ------------------------------------------------------------------
// bin2bcd_seq : sequential double-dabble binary to 4-digit BCD (rev 1.0)
// ------------------------------------------------------------------
module bin2bcd_seq
  import seg_scan_display_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [15:0]      bcd
);

  localparam int CNT_W = $clog2(BIN_W);

  conv_state_t      state;
  logic [BIN_W-1:0] bin_q;
  logic [15:0]      acc;
  logic [15:0]      adj;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // A start in any state reloads from the new snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      bin_q <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      state <= ST_SHIFT;
      bin_q <= bin;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_SHIFT: begin
          acc   <= {adj[14:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd = acc;

endmodule
`default_nettype wire

// File: rtl/seg_scan_display.sv
`default_nettype none
// ------------------------------------------------------------------
// seg_scan_display : 4-digit multiplexed common-anode 7-seg driver (rev 1.0)
// ------------------------------------------------------------------
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int BIN_W    = 14,
  parameter bit LZ_BLANK = 1'b1,
  parameter int N_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             segclk,
  input  logic [BIN_W-1:0] score,
  input  logic             blank,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             busy
);

  localparam int IDX_W = $clog2(N_DIGITS);

  logic [1:0]       sync_q;
  logic             sync_prev;
  logic [1:0]       fill;
  logic             armed;
  logic             scan_tick;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic             live;
  logic             live_next;
  logic             frame_start;
  logic [BIN_W-1:0] score_clamped;
  logic             conv_done;
  logic [15:0]      conv_bcd;
  logic [15:0]      disp;
  logic [3:0]       nib;
  logic             lz;
  logic [6:0]       digit_seg;

  // Edges are only armed once a low level has passed through the filled
  // synchroniser, so segclk already high at reset release yields no tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      sync_prev <= 1'b0;
      fill      <= '0;
      armed     <= 1'b0;
      scan_tick <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], segclk};
      sync_prev <= sync_q[1];
      fill      <= {fill[0], 1'b1};
      armed     <= armed | (fill[1] & ~sync_q[1]);
      scan_tick <= armed & sync_q[1] & ~sync_prev;
    end
  end

  assign idx_next      = scan_tick ? idx + IDX_W'(1) : idx;
  assign live_next     = live | scan_tick;
  assign frame_start   = scan_tick && (idx == IDX_W'(N_DIGITS - 1));
  assign score_clamped = (score > BIN_W'(DISP_MAX)) ? BIN_W'(DISP_MAX) : score;

  bin2bcd_seq #(
    .BIN_W (BIN_W)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (frame_start),
    .bin   (score_clamped),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_comb begin
    nib = disp[{idx_next, 2'b00} +: 4];
    case (idx_next)
      2'd1:    lz = (disp[15:4] == 12'd0);
      2'd2:    lz = (disp[15:8] == 8'd0);
      2'd3:    lz = (disp[15:12] == 4'd0);
      default: lz = 1'b0;
    endcase
    digit_seg = (LZ_BLANK && lz) ? SEG_BLANK : seg_decode(nib);
  end

  // Anodes stay dark until the first scan tick after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= IDX_W'(N_DIGITS - 1);
      live <= 1'b0;
      disp <= '0;
      an   <= 4'hF;
      seg  <= SEG_BLANK;
    end else begin
      idx  <= idx_next;
      live <= live_next;
      if (conv_done) disp <= conv_bcd;
      if (live_next && !blank) begin
        an  <= ~(4'b0001 << idx_next);
        seg <= digit_seg;
      end else begin
        an  <= 4'hF;
        seg <= SEG_BLANK;
      end
    end
  end

  assign dp = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_display.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_seg_scan_display : directed + random bench with arithmetic display model (rev 1.0)
// ------------------------------------------------------------------
module tb_seg_scan_display;

  logic        clk;
  logic        rst;
  logic        segclk;
  logic [13:0] score;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: digit index, display lit, blank, shown value.
  int idx_m   = 3;
  bit live_m  = 0;
  bit blank_m = 0;
  int cur     = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_scan_display dut (
    .clk    (clk),
    .rst    (rst),
    .segclk (segclk),
    .score  (score),
    .blank  (blank),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [3:0] exp_an(input int i);
    logic [3:0] a;
    a = 4'hF;
    if (live_m && !blank_m) a[i] = 1'b0;
    return a;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (!live_m || blank_m) return 7'h7F;
    if (i > 0 && v < p) return 7'h7F;
    return seg_tab[(v / p) % 10];
  endfunction

  // One segclk period of 64 clk; called and returns on a falling clk edge.
  task automatic do_rise(input int chg_at, input int chg_val, input int unblank_at);
    logic [3:0] an_old;
    int busy_cnt;
    bit fs;
    int snap;
    an_old   = exp_an(idx_m);
    busy_cnt = 0;
    fs       = 0;
    snap     = 0;
    segclk   = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 32) segclk = 1'b0;
      if (k == 3) check("an_hold", an, an_old);
      if (k == 4) begin
        idx_m  = (idx_m + 1) % 4;
        live_m = 1;
        fs     = (idx_m == 0);
        if (fs) snap = clamp(int'(score));
        check("an_step", an, exp_an(idx_m));
        check("seg_step", seg, exp_seg(cur, idx_m));
      end
      if (k >= 4 && busy === 1'b1) busy_cnt++;
      if (blank_m) check("an_blank", an, 4'hF);
      if (unblank_at > 0 && k == unblank_at + 1) begin
        check("an_unblank", an, exp_an(idx_m));
        check("seg_unblank", seg, exp_seg(cur, idx_m));
      end
      if (k == unblank_at) begin
        blank   = 1'b0;
        blank_m = 0;
      end
      if (k == chg_at) score = 14'(chg_val);
    end
    if (fs) cur = snap;
    check("busy_len", busy_cnt, fs ? 15 : 0);
    check("seg_end", seg, exp_seg(cur, idx_m));
    check("dp", dp, 1'b1);
  endtask

  task automatic do_frame(input int s, input int chg_at, input int chg_val);
    score = 14'(s);
    do_rise(chg_at, chg_val, -1);
    repeat (3) do_rise(-1, 0, -1);
  endtask

  initial begin
    rst    = 1'b1;
    segclk = 1'b0;
    blank  = 1'b0;
    score  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_dp", dp, 1'b1);
      check("rst_busy", busy, 1'b0);
    end

    do_frame(1234, -1, 0);
    do_frame(1234, -1, 0);
    do_frame(7, -1, 0);
    do_frame(0, -1, 0);
    do_frame(12000, 10, 5);
    do_frame(5, -1, 0);

    blank   = 1'b1;
    blank_m = 1;
    do_frame(5, -1, 0);
    do_rise(-1, 0, 20);
    repeat (3) do_rise(-1, 0, -1);

    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) do_frame(int'($urandom_range(0, 16383)), -1, 0);
      else do_frame(int'($urandom_range(0, 120)), -1, 0);
    end

    score  = 14'd4321;
    segclk = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    idx_m  = 3;
    live_m = 0;
    cur    = 0;
    repeat (30) @(negedge clk);
    check("hi_rel_an", an, 4'hF);
    check("hi_rel_busy", busy, 1'b0);
    segclk = 1'b0;
    repeat (32) @(negedge clk);
    check("hi_rel_notick", an, 4'hF);
    do_frame(4321, -1, 0);
    do_frame(4321, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
